// File: rtl/fact_pkg.sv
// fact_pkg: register map, control/status bit positions and FSM states of the factorial accelerator
package fact_pkg;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int GO_BIT   = 0;
    localparam int IE_BIT   = 1;

    localparam int DONE_BIT = 0;
    localparam int ERR_BIT  = 1;
    localparam int BUSY_BIT = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/fact_mul_step.sv
// fact_mul_step: one full-width multiply of the running product by the counter, with overflow flag
module fact_mul_step #(
    parameter int W  = 32,
    parameter int NW = 4
) (
    input  logic [W-1:0]  prod,
    input  logic [NW-1:0] cnt,
    output logic [W-1:0]  nxt,
    output logic          ovf
);

    logic [2*W-1:0] full;

    assign full = (2*W)'(prod) * (2*W)'(cnt);
    assign nxt  = full[W-1:0];
    assign ovf  = |full[2*W-1:W];

endmodule

// File: rtl/fact_accel.sv
// fact_accel: memory-mapped iterative factorial engine with overflow detection, busy write-lock and interrupt
module fact_accel
    import fact_pkg::*;
#(
    parameter int W  = 32,
    parameter int NW = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [1:0]    A,
    input  logic          WE,
    input  logic [NW-1:0] WD,
    output logic [W-1:0]  RD,
    output logic          Irq
);

    state_t        st, nxt_st;
    logic [NW-1:0] n, cnt;
    logic [W-1:0]  prod, result, mul_nxt;
    logic          ie, ovf, busy, done, err, wr_ok, go, cnt_le1;

    fact_mul_step #(.W(W), .NW(NW)) u_step (
        .prod (prod),
        .cnt  (cnt),
        .nxt  (mul_nxt),
        .ovf  (ovf)
    );

    assign wr_ok   = WE && !busy;
    assign go      = wr_ok && A == ADDR_CTRL && WD[GO_BIT];
    assign cnt_le1 = cnt <= NW'(1);

    // state register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) st <= S_IDLE;
        else     st <= nxt_st;
    end

    // next state: GO is only honoured outside MUL; MUL ends on the last factor or an overflow
    always_comb begin
        nxt_st = st;
        if (st == S_MUL) nxt_st = cnt_le1 ? S_DONE : ovf ? S_ERR : S_MUL;
        else if (go)     nxt_st = S_MUL;
    end

    // status flags decoded from state, interrupt is level from the sticky flags
    always_comb begin
        busy = st == S_MUL;
        done = st == S_DONE;
        err  = st == S_ERR;
        Irq  = ie && (done || err);
    end

    // software-visible registers, all writes dropped while busy
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            n  <= '0;
            ie <= 1'b0;
        end else if (wr_ok) begin
            if (A == ADDR_N)    n  <= WD;
            if (A == ADDR_CTRL) ie <= WD[IE_BIT];
        end
    end

    // datapath: load on GO, then multiply downward; result is published only on a clean finish
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
        end else if (go) begin
            cnt    <= n;
            prod   <= W'(1);
            result <= '0;
        end else if (busy) begin
            if (cnt_le1) result <= prod;
            else if (!ovf) begin
                prod <= mul_nxt;
                cnt  <= cnt - NW'(1);
            end
        end
    end

    // read mux, combinational from the address
    always_comb begin
        RD = A == ADDR_N      ? W'(n) :
             A == ADDR_CTRL   ? W'({ie, 1'b0}) :
             A == ADDR_STATUS ? W'({busy, err, done}) : result;
    end

endmodule

// File: tb/tb_fact_accel.sv
// tb_fact_accel: directed checks of the factorial accelerator at W=32 and W=16
module tb_fact_accel;
    import fact_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [1:0]  A   = 2'd0;
    logic        WE  = 1'b0;
    logic [3:0]  WD  = 4'd0;
    logic [31:0] rd32;
    logic [15:0] rd16;
    logic        irq32, irq16;
    int          n_cmp = 0;
    int          n_bad = 0;

    fact_accel #(.W(32), .NW(4)) u32 (
        .Clk(Clk), .Rst(Rst), .A(A), .WE(WE), .WD(WD), .RD(rd32), .Irq(irq32)
    );

    fact_accel #(.W(16), .NW(4)) u16 (
        .Clk(Clk), .Rst(Rst), .A(A), .WE(WE), .WD(WD), .RD(rd16), .Irq(irq16)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input bit w16, output logic [31:0] v);
        A = a;
        #1;
        v = w16 ? {16'd0, rd16} : rd32;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        A  = a;
        WD = d;
        WE = 1'b1;
        @(posedge Clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic idle();
        repeat (16) @(posedge Clk);
        #1;
    endtask

    task automatic go_run(input logic [3:0] n, input bit w16, input int edges,
                          input logic [2:0] fin, input logic [31:0] res);
        logic [31:0] v;
        idle();
        wr(ADDR_N, n);
        wr(ADDR_CTRL, 4'd1);
        rd(ADDR_STATUS, w16, v);
        chk($sformatf("n%0d w16=%0d busy e0", n, w16), v, 32'd4);
        for (int e = 1; e < edges; e++) begin
            @(posedge Clk);
            #1;
            rd(ADDR_STATUS, w16, v);
            chk($sformatf("n%0d w16=%0d busy e%0d", n, w16, e), v, 32'd4);
        end
        @(posedge Clk);
        #1;
        rd(ADDR_STATUS, w16, v);
        chk($sformatf("n%0d w16=%0d final status", n, w16), v, 32'(fin));
        rd(ADDR_RESULT, w16, v);
        chk($sformatf("n%0d w16=%0d result", n, w16), v, res);
    endtask

    initial begin
        logic [31:0] v;
        #2;
        rd(ADDR_STATUS, 0, v); chk("rst status", v, 0);
        rd(ADDR_RESULT, 0, v); chk("rst result", v, 0);
        rd(ADDR_N, 0, v);      chk("rst n", v, 0);
        rd(ADDR_CTRL, 0, v);   chk("rst ctrl", v, 0);
        chk("rst irq", 32'(irq32), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;

        go_run(4'd7,  0, 7,  3'b001, 32'd5040);
        rd(ADDR_N, 0, v); chk("n readback", v, 7);
        go_run(4'd13, 0, 12, 3'b010, 32'd0);
        go_run(4'd12, 0, 12, 3'b001, 32'd479001600);
        go_run(4'd8,  1, 8,  3'b001, 32'd40320);
        go_run(4'd9,  1, 7,  3'b010, 32'd0);
        go_run(4'd0,  0, 1,  3'b001, 32'd1);
        go_run(4'd1,  0, 1,  3'b001, 32'd1);

        idle();
        wr(ADDR_N, 4'd7);
        wr(ADDR_CTRL, 4'd3);
        rd(ADDR_CTRL, 0, v); chk("ie stored with go", v, 2);
        chk("irq low while busy", 32'(irq32), 0);
        wr(ADDR_N, 4'd3);
        wr(ADDR_CTRL, 4'd1);
        repeat (5) @(posedge Clk);
        #1;
        rd(ADDR_STATUS, 0, v); chk("prot status", v, 1);
        rd(ADDR_RESULT, 0, v); chk("prot result", v, 5040);
        rd(ADDR_N, 0, v);      chk("prot n kept", v, 7);
        rd(ADDR_CTRL, 0, v);   chk("prot ie kept", v, 2);
        chk("irq with done", 32'(irq32), 1);
        wr(ADDR_CTRL, 4'd0);
        chk("irq after ie=0", 32'(irq32), 0);
        rd(ADDR_STATUS, 0, v); chk("done sticky", v, 1);
        wr(ADDR_N, 4'd3);
        wr(ADDR_CTRL, 4'd1);
        repeat (3) @(posedge Clk);
        #1;
        rd(ADDR_RESULT, 0, v); chk("n3 result", v, 6);
        chk("irq off ie=0", 32'(irq32), 0);

        idle();
        wr(ADDR_N, 4'd10);
        wr(ADDR_CTRL, 4'd3);
        repeat (3) @(posedge Clk);
        #1;
        rd(ADDR_STATUS, 0, v); chk("pre-rst busy", v, 4);
        Rst = 1'b1;
        #1;
        chk("async rst status", 32'(rd32), 0);
        rd(ADDR_RESULT, 0, v); chk("async rst result", v, 0);
        rd(ADDR_N, 0, v);      chk("async rst n", v, 0);
        rd(ADDR_CTRL, 0, v);   chk("async rst ctrl", v, 0);
        chk("async rst irq", 32'(irq32), 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        go_run(4'd5, 0, 5, 3'b001, 32'd120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
